// File: rtl/cfg_pkg.sv
// Shared configuration types and Cyclone IV E timing constants used by the
// configuration starter and the passive-serial loader.
`timescale 1ns/1ps
package cfg_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_FETCH     = 3'd1,
      ST_SHIFT     = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_INIT      = 3'd4,
      ST_DONE      = 3'd5,
      ST_ERROR     = 3'd6
   } ps_state_t;

   // Cyclone IV E passive-serial MSEL strap and nCONFIG timing (ns)
   localparam logic [3:0]  CIV_MSEL_PS     = 4'b1101;
   localparam int unsigned CIV_TCFG_NS     = 32'd500;
   localparam int unsigned CIV_TCF2CK_NS   = 32'd230000;
   localparam int unsigned CIV_INIT_CLOCKS = 32'd3192;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      if (a > b) begin
         return a;
      end else begin
         return b;
      end
   endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous target status pins; clears to 0.
`timescale 1ns/1ps
module sync2 (
   input  logic clock_i,
   input  logic reset_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // metastability stage followed by the stable output stage
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/ps_loader.sv
// Passive-serial bitstream shifter: bytes go out LSB-first on DATA0 under a
// divided DCLK, then CONF_DONE is awaited and the init clocks are issued.
`timescale 1ns/1ps
module ps_loader
   import cfg_pkg::*;
#(
   parameter int unsigned CLK_DIV      = 32'd5,
   parameter int unsigned INIT_CLOCKS  = CIV_INIT_CLOCKS,
   parameter int unsigned DONE_TIMEOUT = 32'd1024
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] s_data,
   input  logic       s_valid,
   input  logic       s_last,
   output logic       s_ready,
   output logic       dclk,
   output logic       data0,
   input  logic       n_status,
   input  logic       conf_done,
   output logic       busy,
   output logic       done,
   output logic       error
);

   localparam int unsigned DW = $clog2(CLK_DIV + 32'd1);
   localparam int unsigned CW = $clog2(max_u(INIT_CLOCKS, DONE_TIMEOUT) + 32'd1);
   localparam logic [DW-1:0] DIV_LAST     = DW'(CLK_DIV - 32'd1);
   localparam logic [CW-1:0] INIT_LAST    = CW'(INIT_CLOCKS);
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(DONE_TIMEOUT);

   ps_state_t     state_q, state_d;
   logic          dclk_q, dclk_d;
   logic          data0_q, data0_d;
   logic [6:0]    shift_q, shift_d;
   logic          last_q, last_d;
   logic [2:0]    bit_q, bit_d;
   logic [DW-1:0] div_q, div_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          s_ready_q, busy_q, done_q, error_q;

   logic          ns_sync_s, cd_sync_s;
   logic          phase_end_s, cycle_end_s, ns_fail_s, handshake_s;
   logic [DW-1:0] div_run_s;
   logic          dclk_run_s;
   logic [CW-1:0] cnt_inc_s;

   sync2 u_sync_nstatus (
      .clock_i (clock),
      .reset_i (reset),
      .d_i     (n_status),
      .q_o     (ns_sync_s)
   );

   sync2 u_sync_confdone (
      .clock_i (clock),
      .reset_i (reset),
      .d_i     (conf_done),
      .q_o     (cd_sync_s)
   );

   // A full DCLK cycle ends on the last cycle of the high phase.
   assign phase_end_s = (div_q == DIV_LAST);
   assign cycle_end_s = phase_end_s && dclk_q;
   assign div_run_s   = phase_end_s ? {DW{1'b0}} : (div_q + {{(DW-1){1'b0}}, 1'b1});
   assign dclk_run_s  = phase_end_s ? ~dclk_q : dclk_q;
   assign cnt_inc_s   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
   assign handshake_s = s_valid && s_ready_q;
   assign ns_fail_s   = !ns_sync_s &&
                        (state_q inside {ST_FETCH, ST_SHIFT, ST_WAIT_DONE, ST_INIT});

   // next-state and datapath decode
   always_comb begin
      state_d = state_q;
      dclk_d  = dclk_q;
      data0_d = data0_q;
      shift_d = shift_q;
      last_d  = last_q;
      bit_d   = bit_q;
      div_d   = div_q;
      cnt_d   = cnt_q;

      case (state_q)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (start) begin
               state_d = ST_FETCH;
            end else begin
               state_d = state_q;
            end
         end
         ST_FETCH: begin
            dclk_d = 1'b0;
            if (handshake_s) begin
               shift_d = s_data[7:1];
               data0_d = s_data[0];
               last_d  = s_last;
               bit_d   = 3'd0;
               div_d   = {DW{1'b0}};
               state_d = ST_SHIFT;
            end else begin
               state_d = ST_FETCH;
            end
         end
         ST_SHIFT: begin
            div_d  = div_run_s;
            dclk_d = dclk_run_s;
            if (cycle_end_s && (bit_q == 3'd7)) begin
               if (last_q) begin
                  data0_d = 1'b1;
                  cnt_d   = {CW{1'b0}};
                  state_d = ST_WAIT_DONE;
               end else begin
                  state_d = ST_FETCH;
               end
            end else if (cycle_end_s) begin
               bit_d   = bit_q + 3'd1;
               data0_d = shift_q[0];
               shift_d = {1'b0, shift_q[6:1]};
            end else begin
               state_d = ST_SHIFT;
            end
         end
         ST_WAIT_DONE: begin
            if (cd_sync_s) begin
               cnt_d   = {CW{1'b0}};
               div_d   = {DW{1'b0}};
               dclk_d  = 1'b0;
               state_d = ST_INIT;
            end else begin
               div_d  = div_run_s;
               dclk_d = dclk_run_s;
               if (cycle_end_s) begin
                  cnt_d = cnt_inc_s;
                  if (cnt_inc_s == TIMEOUT_LAST) begin
                     state_d = ST_ERROR;
                  end else begin
                     state_d = ST_WAIT_DONE;
                  end
               end else begin
                  state_d = ST_WAIT_DONE;
               end
            end
         end
         ST_INIT: begin
            div_d  = div_run_s;
            dclk_d = dclk_run_s;
            if (cycle_end_s) begin
               cnt_d = cnt_inc_s;
               if (cnt_inc_s == INIT_LAST) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_INIT;
               end
            end else begin
               state_d = ST_INIT;
            end
         end
         default: begin
            state_d = ST_IDLE;
            dclk_d  = 1'b0;
         end
      endcase

      // a target fault overrides whatever the state machine decided
      if (ns_fail_s) begin
         state_d = ST_ERROR;
         dclk_d  = 1'b0;
      end else begin
         state_d = state_d;
      end
   end

   // state, datapath and registered status outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         dclk_q    <= 1'b0;
         data0_q   <= 1'b0;
         shift_q   <= 7'd0;
         last_q    <= 1'b0;
         bit_q     <= 3'd0;
         div_q     <= {DW{1'b0}};
         cnt_q     <= {CW{1'b0}};
         s_ready_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         dclk_q    <= dclk_d;
         data0_q   <= data0_d;
         shift_q   <= shift_d;
         last_q    <= last_d;
         bit_q     <= bit_d;
         div_q     <= div_d;
         cnt_q     <= cnt_d;
         s_ready_q <= (state_d == ST_FETCH);
         busy_q    <= !(state_d inside {ST_IDLE, ST_DONE, ST_ERROR});
         done_q    <= (state_d == ST_DONE);
         error_q   <= (state_d == ST_ERROR);
      end
   end

   assign s_ready = s_ready_q;
   assign dclk    = dclk_q;
   assign data0   = data0_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign error   = error_q;

endmodule

// File: tb/tb_ps_loader.sv
// Self-checking bench for ps_loader: table of transfer scenarios with random
// bytes and gaps, compared against a bit-stream model, plus fault/reset cases.
`timescale 1ns/1ps
module tb_ps_loader;

   localparam int CLK_DIV      = 2;
   localparam int INIT_CLOCKS  = 8;
   localparam int DONE_TIMEOUT = 16;
   localparam int LIMIT        = 20000;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [7:0] s_data = 8'h00;
   logic       s_valid = 1'b0;
   logic       s_last = 1'b0;
   logic       s_ready;
   logic       dclk;
   logic       data0;
   logic       n_status = 1'b1;
   logic       conf_done = 1'b0;
   logic       busy;
   logic       done;
   logic       error;

   always #5 clock = ~clock;

   ps_loader #(
      .CLK_DIV      (CLK_DIV),
      .INIT_CLOCKS  (INIT_CLOCKS),
      .DONE_TIMEOUT (DONE_TIMEOUT)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .s_data    (s_data),
      .s_valid   (s_valid),
      .s_last    (s_last),
      .s_ready   (s_ready),
      .dclk      (dclk),
      .data0     (data0),
      .n_status  (n_status),
      .conf_done (conf_done),
      .busy      (busy),
      .done      (done),
      .error     (error)
   );

   typedef struct {
      int nbytes;
      int fixed;
      int gap1;
      int rnd_gap;
      int cd_after;
      int spam;
      int exp_done;
      int exp_error;
      int exp_post;
   } vec_t;

   int n_cmp = 0;
   int n_bad = 0;

   // observation log kept by the monitor; the main process only reads it
   logic cap_q[$];
   int   per_q[$];
   int   hi_q[$];
   int   unstable = 0;

   logic [7:0] fixed_b [3];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // DCLK monitor: data0 at each rising edge, rise-to-rise period, high length
   initial begin
      int   cyc;
      int   last_rise;
      int   last_chg;
      logic dclk_p;
      logic data0_p;
      cyc = 0; last_rise = -1000; last_chg = 0; dclk_p = 1'b0; data0_p = 1'b0;
      forever begin
         @(negedge clock);
         cyc++;
         if (dclk === 1'b1 && dclk_p === 1'b0) begin
            cap_q.push_back(data0);
            per_q.push_back(cyc - last_rise);
            last_rise = cyc;
         end
         if (dclk === 1'b0 && dclk_p === 1'b1) hi_q.push_back(cyc - last_chg);
         if (dclk === 1'b1 && dclk_p === 1'b1 && data0 !== data0_p) unstable++;
         if (dclk !== dclk_p) last_chg = cyc;
         dclk_p  = dclk;
         data0_p = data0;
      end
   end

   task automatic pulse_start();
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic last, output logic ok);
      int k;
      @(negedge clock);
      s_data = b; s_last = last; s_valid = 1'b1;
      k = 0;
      while (s_ready !== 1'b1 && k < LIMIT) begin
         @(negedge clock);
         k++;
      end
      ok = (s_ready === 1'b1);
      @(posedge clock);
      #1;
      s_valid = 1'b0; s_last = 1'b0;
   endtask

   task automatic wait_edges(input int base, input int target);
      int k;
      k = 0;
      while (cap_q.size() - base < target && k < LIMIT) begin
         @(negedge clock);
         #1;
         k++;
      end
      check("edge_wait", (cap_q.size() - base >= target), 1);
   endtask

   task automatic run_xfer(input vec_t v, input string tag);
      logic [7:0] b[$];
      logic       exp_bits[$];
      int         base, hbase, ubase, k, mism, bad;
      logic       src_ok, stall_dclk, stall_rdy;
      for (int j = 0; j < v.nbytes; j++) begin
         if (v.fixed != 0) b.push_back(fixed_b[j]);
         else              b.push_back(8'($urandom));
      end
      for (int j = 0; j < v.nbytes; j++)
         for (int i = 0; i < 8; i++) exp_bits.push_back(b[j][i]);
      repeat (v.exp_post) exp_bits.push_back(1'b1);
      base = cap_q.size(); hbase = hi_q.size(); ubase = unstable;
      src_ok = 1'b1; stall_dclk = 1'b0; stall_rdy = 1'b1;
      pulse_start();
      fork
         begin
            logic ok;
            for (int j = 0; j < v.nbytes; j++) begin
               if (j == 1 && v.gap1 > 0) begin
                  repeat (v.gap1) @(negedge clock);
                  stall_dclk = dclk;
                  stall_rdy  = s_ready;
               end else if (v.rnd_gap != 0) begin
                  repeat ($urandom_range(0, 3)) @(negedge clock);
               end
               send_byte(b[j], (j == v.nbytes - 1), ok);
               if (!ok) src_ok = 1'b0;
            end
         end
         begin
            if (v.cd_after >= 0) begin
               int kk;
               kk = 0;
               while (cap_q.size() - base < 8 * v.nbytes + v.cd_after && kk < LIMIT) begin
                  @(negedge clock);
                  #1;
                  kk++;
               end
               conf_done = 1'b1;
            end
         end
         begin
            if (v.spam != 0) begin
               repeat (3) begin
                  repeat ($urandom_range(5, 20)) @(negedge clock);
                  if (busy === 1'b1 && cap_q.size() - base < 8 * v.nbytes - 1) begin
                     start = 1'b1;
                     @(negedge clock);
                     start = 1'b0;
                  end
               end
            end
         end
      join
      k = 0;
      while (done !== 1'b1 && error !== 1'b1 && k < LIMIT) begin
         @(negedge clock);
         k++;
      end
      @(negedge clock);
      check({tag, "_src"}, src_ok, 1);
      check({tag, "_done"}, done, v.exp_done);
      check({tag, "_error"}, error, v.exp_error);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_idle_out"}, {dclk, s_ready}, 0);
      check({tag, "_edges"}, cap_q.size() - base, exp_bits.size());
      mism = 0;
      for (int e = 0; e < exp_bits.size(); e++)
         if (base + e >= cap_q.size() || cap_q[base + e] !== exp_bits[e]) mism++;
      check({tag, "_bits"}, mism, 0);
      bad = 0;
      for (int e = hbase; e < hi_q.size(); e++) if (hi_q[e] != CLK_DIV) bad++;
      check({tag, "_hi_len"}, bad, 0);
      check({tag, "_hi_cnt"}, hi_q.size() - hbase, exp_bits.size());
      bad = 0;
      for (int e = 1; e < 8 * v.nbytes && base + e < per_q.size(); e++)
         if (e % 8 != 0 && per_q[base + e] != 2 * CLK_DIV) bad++;
      check({tag, "_period"}, bad, 0);
      check({tag, "_stable"}, unstable - ubase, 0);
      if (v.gap1 >= 40) begin
         check({tag, "_stall_dclk"}, stall_dclk, 0);
         check({tag, "_stall_rdy"}, stall_rdy, 1);
      end
      conf_done = 1'b0;
      repeat (3) @(negedge clock);
   endtask

   initial begin
      vec_t vecs[6];
      vec_t rec;
      logic ok;
      int   base, k, e1;

      fixed_b[0] = 8'hA5; fixed_b[1] = 8'h3C; fixed_b[2] = 8'hFF;
      //         n  fix gap1 rnd  cd spam done err post
      vecs[0] = '{3, 1,  0,  0,  5, 0,   1,   0,  5 + INIT_CLOCKS};
      vecs[1] = '{3, 1, 50,  0,  5, 0,   1,   0,  5 + INIT_CLOCKS};
      vecs[2] = '{2, 0,  0,  0, -1, 0,   0,   1,  DONE_TIMEOUT};
      vecs[3] = '{5, 0,  0,  1,  0, 0,   1,   0,  INIT_CLOCKS};
      vecs[4] = '{4, 0,  0,  1,  9, 1,   1,   0,  9 + INIT_CLOCKS};
      vecs[5] = '{1, 0,  0,  0, 15, 0,   1,   0,  15 + INIT_CLOCKS};

      repeat (4) @(posedge clock);
      #1;
      check("reset_outs", {dclk, data0, s_ready, busy, done, error}, 0);
      @(negedge clock);
      reset = 1'b0;
      repeat (4) @(negedge clock);
      check("idle_outs", {s_ready, busy, done, error}, 0);

      for (int i = 0; i < 6; i++) run_xfer(vecs[i], $sformatf("vec%0d", i));

      // n_status fault during bit 4 of the second byte
      base = cap_q.size();
      pulse_start();
      send_byte(8'($urandom), 1'b0, ok);
      send_byte(8'($urandom), 1'b0, ok);
      wait_edges(base, 8 + 5);
      n_status = 1'b0;
      k = 0;
      while (error !== 1'b1 && k < 3) begin
         @(posedge clock);
         #1;
         k++;
      end
      check("ns_error", error, 1);
      check("ns_dclk", dclk, 0);
      check("ns_ready", s_ready, 0);
      check("ns_busy", busy, 0);
      e1 = cap_q.size();
      repeat (20) @(negedge clock);
      check("ns_no_edges", cap_q.size() - e1, 0);
      n_status = 1'b1;
      repeat (4) @(negedge clock);
      rec = '{2, 0, 0, 1, 3, 0, 1, 0, 3 + INIT_CLOCKS};
      run_xfer(rec, "after_fault");

      // reset in the middle of a byte
      base = cap_q.size();
      pulse_start();
      send_byte(8'($urandom), 1'b0, ok);
      wait_edges(base, 3);
      reset = 1'b1;
      @(posedge clock);
      #1;
      check("rst_mid_outs", {dclk, data0, s_ready, busy, done, error}, 0);
      @(negedge clock);
      reset = 1'b0;
      repeat (4) @(negedge clock);
      check("rst_idle", {s_ready, busy, done, error}, 0);
      rec = '{3, 0, 0, 1, 2, 1, 1, 0, 2 + INIT_CLOCKS};
      run_xfer(rec, "after_reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
